step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Run-control front end feeding the fir_filter ASIP pipeline.
- Conditions the raw board inputs pwr, dbg and stp: synchronise, debounce, detect edges.
- Produces a single pipeline-advance enable that supports free-run, halt and single-step debug.
- Sits between the board switches/buttons and the core's stage-register enables.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a filtered input changes (minimum 1).
- STEP_CYCLES, 1: cycles en stays high per single step (minimum 1).
- CNT_W, 16: width of step_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pwr  in  1  raw power switch; 1 = on.
- dbg  in  1  raw debug-mode switch; 1 = debug (halt/step).
- stp  in  1  raw step push-button, active-low; idle = 1.
- en  out  1  pipeline advance enable.
- step_done  out  1  one-cycle pulse when a step finishes.
- halted  out  1  1 while in HALT.
- state  out  2  current FSM state.
- step_count  out  CNT_W  completed-step counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=OFF; en=0, step_done=0, halted=0, step_count=0.
  - Sync/filter flops load idle values: pwr=0, dbg=0, stp=1.
  - Debounce counters=0; step counter=0.
- Input conditioning, per input:
  - 2-flop synchroniser.
  - Filtered value copies the synchronised value only after the two differ for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreement cycle clears that input's counter.
  - Raw change to filtered change = 2+DEBOUNCE_CYCLES edges.
- press = registered one-cycle pulse on a 1->0 transition of filtered stp.
- FSM states, encoding fixed: OFF=0, RUN=1, HALT=2, STEP=3.
- Transition priority:
  - 1. pwr_f=0 forces OFF from any state, aborting STEP without a step_done pulse.
  - 2. Then per-state rules below.
- OFF: pwr_f=1 -> HALT if dbg_f=1, else RUN.
- RUN: dbg_f=1 -> HALT.
- HALT: press -> STEP (press has priority if dbg_f falls the same cycle); else dbg_f=0 -> RUN.
- STEP:
  - Counts STEP_CYCLES cycles, then returns to HALT.
  - step_done pulses in the last STEP cycle.
  - Presses during STEP are discarded, not queued.
  - dbg_f falling during STEP takes effect from HALT after the step completes.
- Outputs (Moore, decoded from the state register):
  - en=1 in RUN and STEP.
  - halted=1 in HALT.
  - state = the encoding above.
  - en changes on the edge after the filtered input changes.
- step_count:
  - Increments on step_done, saturating at all-ones.
  - Cleared only by rst; unaffected by OFF.
- Reset mid-STEP: immediate return to OFF with en=0; no step_done pulse.

Optional Feature:
- Macro: STEP_CTRL_COUNT_EN.
- Defined: step_count behaves as above.
- Undefined: counter logic is omitted and step_count is tied to 0. Port list is unchanged.

Decomposition:
- Package step_ctrl_pkg holds:
  - typedef enum logic [1:0] run_state_t {OFF, RUN, HALT, STEP};
  - localparam idle values for the pwr, dbg and stp filters.
- Sub-module input_debouncer:
  - Parameters: DEBOUNCE_CYCLES, IDLE_VAL.
  - Contains the 2-flop sync plus stability counter and filtered output.
  - Instantiated three times.
- FSM, step timer and counter stay in step_controller.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=1, macro defined):
- Reset values:
  - Stimulus: assert rst=0 with pwr=1, dbg=1, stp=0.
  - Response: en=0, state=0, step_count=0 throughout reset; no press pulse after release until stp is seen high then low.
- Free-run power-up:
  - Stimulus: dbg=0; pwr rises at edge k.
  - Response: en=1 and state=1 from edge k+7; pwr glitch 1 for 3 cycles -> state stays 0.
- Debug power-up and single step:
  - Stimulus: dbg=1, pwr=1 -> state=2, halted=1; stp low for 10 cycles.
  - Response: exactly one cycle with en=1 and step_done=1; state back to 2; step_count=1.
- Repeated and bouncing presses:
  - Stimulus: 5 clean presses spaced 20 cycles apart; then stp toggling every 2 cycles for 20 cycles.
  - Response: step_count=5; no extra step from the bounce.
- Debug exit and power loss:
  - Stimulus: in HALT, dbg falls.
  - Response: state=1 and en=1 after 7 edges.
  - Stimulus: pwr falls during RUN.
  - Response: state=0 and en=0 after 7 edges.
- Saturation and async reset:
  - Stimulus: preload counter or use CNT_W=2 and perform 5 steps; then pulse rst low between edges.
  - Response: step_count holds at 3; after the rst pulse, outputs clear immediately, with no clock edge required.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared types and idle levels for the step_controller run-control front end.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } run_state_t;

  localparam logic PWR_IDLE = 1'b0;
  localparam logic DBG_IDLE = 1'b0;
  localparam logic STP_IDLE = 1'b1;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability filter: the filtered value
// follows the synchronised value once they have differed DEBOUNCE_CYCLES times in a row.
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic IDLE_VAL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt;

  // NOTE: every flop in a clocked block uses <= so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= IDLE_VAL;
      sync_q <= IDLE_VAL;
      filt_q <= IDLE_VAL;
      cnt    <= '0;
    end else begin
      meta   <= raw;
      sync_q <= meta;
      if (sync_q == filt_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt_q <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/step_controller.sv
// Run-control front end: debounced pwr/dbg/stp drive an OFF/RUN/HALT/STEP FSM
// producing the pipeline enable. Define STEP_CTRL_COUNT_EN to build the step counter.
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr,
  input  logic             dbg,
  input  logic             stp,
  output logic             en,
  output logic             step_done,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam int TW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(STEP_CYCLES - 1);
  localparam int WARM = DEBOUNCE_CYCLES + 2;
  localparam int WW   = $clog2(WARM + 1);

  logic pwr_f, dbg_f, stp_f;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_VAL(PWR_IDLE)) u_pwr (
    .clk(clk), .rst(rst), .raw(pwr), .filt(pwr_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_VAL(DBG_IDLE)) u_dbg (
    .clk(clk), .rst(rst), .raw(dbg), .filt(dbg_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_VAL(STP_IDLE)) u_stp (
    .clk(clk), .rst(rst), .raw(stp), .filt(stp_f));

  // Press detection arms only once the filter has had time to reflect the real
  // pin, so a button held through reset does not count as a press.
  logic [WW-1:0] warm;
  logic          warm_done;
  logic          armed;
  logic          stp_prev;
  logic          press;

  assign warm_done = (warm == WW'(WARM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm     <= '0;
      armed    <= 1'b0;
      stp_prev <= STP_IDLE;
      press    <= 1'b0;
    end else begin
      if (!warm_done) warm <= warm + 1'b1;
      armed    <= armed | (warm_done & stp_f);
      stp_prev <= stp_f;
      press    <= armed & stp_prev & ~stp_f;
    end
  end

  run_state_t    state_q, state_d;
  logic [TW-1:0] step_cnt;
  logic          step_last;

  assign step_last = (step_cnt == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= OFF;
      step_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != STEP)  step_cnt <= '0;
      else if (!step_last)  step_cnt <= step_cnt + 1'b1;
    end
  end

  // NOTE: next state defaults to the current state before any branch, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!pwr_f) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = dbg_f ? HALT : RUN;
        RUN:     if (dbg_f) state_d = HALT;
        HALT:    if (press) state_d = STEP;
                 else if (!dbg_f) state_d = RUN;
        STEP:    if (step_last) state_d = HALT;
        default: state_d = OFF;
      endcase
    end
  end

  // A power loss in the final STEP cycle aborts the step, so no completion pulse.
  assign step_done = (state_q == STEP) && step_last && pwr_f;
  assign en        = (state_q == RUN) || (state_q == STEP);
  assign halted    = (state_q == HALT);
  assign state     = state_q;

`ifdef STEP_CTRL_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (step_done && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign step_count = count_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller (DEBOUNCE_CYCLES=4, STEP_CYCLES=1); a
// second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_step_controller;

`ifdef STEP_CTRL_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pwr, dbg, stp;
  logic        en, step_done, halted;
  logic [1:0]  state;
  logic [15:0] step_count;
  logic        en_s, step_done_s, halted_s;
  logic [1:0]  state_s;
  logic [1:0]  step_count_s;

  int checks   = 0;
  int errors   = 0;
  int en_sum   = 0;
  int done_sum = 0;
  int both_sum = 0;

  always #5 clk = ~clk;

  step_controller #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
    .en(en), .step_done(step_done), .halted(halted),
    .state(state), .step_count(step_count));

  step_controller #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
    .en(en_s), .step_done(step_done_s), .halted(halted_s),
    .state(state_s), .step_count(step_count_s));

  function automatic int exp_cnt(input int n, input int max);
    if (!COUNT_EN) return 0;
    return (n > max) ? max : n;
  endfunction

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    en_sum   += int'(en);
    done_sum += int'(step_done);
    both_sum += int'(en && step_done);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_sums();
    en_sum = 0; done_sum = 0; both_sum = 0;
  endtask

  task automatic press_once();
    stp = 1'b0; ticks(10);
    stp = 1'b1; ticks(10);
  endtask

  task automatic test_reset();
    rst = 1'b0; pwr = 1'b1; dbg = 1'b1; stp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (en !== 1'b0 || state !== 2'd0 || step_count !== 16'd0 || step_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: en=%b state=%0d count=%0d done=%b, need 0/0/0/0",
                 i, en, state, step_count, step_done);
      end
    end
    rst = 1'b1;
    clear_sums();
    ticks(20);
    checks++;
    if (state !== 2'd2 || halted !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_halt: state=%0d halted=%b, need 2/1", state, halted);
    end
    checks++;
    if (en_sum !== 0) begin
      errors++;
      $display("FAIL reset_no_press: en cycles=%0d, need 0", en_sum);
    end
    stp = 1'b1; ticks(10);
    pwr = 1'b0; ticks(10);
    checks++;
    if (state !== 2'd0 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_power_off: state=%0d en=%b, need 0/0", state, en);
    end
  endtask

  task automatic test_free_run();
    int bad = 0;
    dbg = 1'b0;
    pwr = 1'b1; ticks(3);
    pwr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (state !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL glitch_ignored: non-OFF cycles=%0d, need 0", bad);
    end
    pwr = 1'b1;
    ticks(6);
    checks++;
    if (state !== 2'd0 || en !== 1'b0) begin
      errors++;
      $display("FAIL power_up_edge6: state=%0d en=%b, need 0/0", state, en);
    end
    tick();
    checks++;
    if (state !== 2'd1 || en !== 1'b1) begin
      errors++;
      $display("FAIL power_up_edge7: state=%0d en=%b, need 1/1", state, en);
    end
  endtask

  task automatic test_single_step();
    dbg = 1'b1; ticks(10);
    checks++;
    if (state !== 2'd2 || halted !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL enter_halt: state=%0d halted=%b en=%b, need 2/1/0", state, halted, en);
    end
    clear_sums();
    press_once();
    checks++;
    if (en_sum !== 1 || done_sum !== 1 || both_sum !== 1) begin
      errors++;
      $display("FAIL single_step: en=%0d done=%0d both=%0d, need 1/1/1", en_sum, done_sum, both_sum);
    end
    checks++;
    if (state !== 2'd2 || int'(step_count) !== exp_cnt(1, 65535)) begin
      errors++;
      $display("FAIL single_step_after: state=%0d count=%0d, need 2/%0d",
               state, step_count, exp_cnt(1, 65535));
    end
  endtask

  task automatic test_back_to_back();
    clear_sums();
    for (int i = 0; i < 5; i++) press_once();
    checks++;
    if (en_sum !== 5 || done_sum !== 5) begin
      errors++;
      $display("FAIL five_presses: en=%0d done=%0d, need 5/5", en_sum, done_sum);
    end
    checks++;
    if (int'(step_count) !== exp_cnt(6, 65535)) begin
      errors++;
      $display("FAIL count_after_six: got %0d need %0d", step_count, exp_cnt(6, 65535));
    end
    checks++;
    if (int'(step_count_s) !== exp_cnt(6, 3)) begin
      errors++;
      $display("FAIL count_saturate: got %0d need %0d", step_count_s, exp_cnt(6, 3));
    end
    clear_sums();
    for (int i = 0; i < 10; i++) begin
      stp = (i % 2 == 1);
      ticks(2);
    end
    ticks(10);
    checks++;
    if (en_sum !== 0 || int'(step_count) !== exp_cnt(6, 65535) || state !== 2'd2) begin
      errors++;
      $display("FAIL bounce_ignored: en=%0d count=%0d state=%0d, need 0/%0d/2",
               en_sum, step_count, state, exp_cnt(6, 65535));
    end
  endtask

  task automatic test_debug_exit();
    dbg = 1'b0; ticks(6);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL dbg_exit_edge6: state=%0d need 2", state);
    end
    tick();
    checks++;
    if (state !== 2'd1 || en !== 1'b1) begin
      errors++;
      $display("FAIL dbg_exit_edge7: state=%0d en=%b, need 1/1", state, en);
    end
    pwr = 1'b0; ticks(6);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL pwr_loss_edge6: state=%0d need 1", state);
    end
    tick();
    checks++;
    if (state !== 2'd0 || en !== 1'b0) begin
      errors++;
      $display("FAIL pwr_loss_edge7: state=%0d en=%b, need 0/0", state, en);
    end
  endtask

  task automatic test_async_reset();
    pwr = 1'b1; ticks(10);
    checks++;
    if (state !== 2'd1 || int'(step_count_s) !== exp_cnt(6, 3)) begin
      errors++;
      $display("FAIL pre_reset: state=%0d sat_count=%0d, need 1/%0d", state, step_count_s, exp_cnt(6, 3));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || state !== 2'd0 || halted !== 1'b0 || step_done !== 1'b0 ||
        step_count !== 16'd0 || step_count_s !== 2'd0 || en_s !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%b state=%0d count=%0d sat=%0d, need 0/0/0/0",
               en, state, step_count, step_count_s);
    end
    ticks(2);
    rst = 1'b1;
    ticks(10);
    checks++;
    if (state !== 2'd1 || en !== 1'b1 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL after_reset_run: state=%0d en=%b count=%0d, need 1/1/0", state, en, step_count);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_back_to_back();
    test_debug_exit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
